// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor
//   Checker for a VGA sync/colour stream. Registers HS/VS once, normalises
//   the sync polarity, locks to the frame on a VS leading edge and then
//   measures line period, HS width, lines per frame and VS width against
//   the configured limits. Frame and error counts are exposed, and a
//   sticky per-check status word records which checks have failed.
//
//   Optional feature macro: VGA_MON_CRC_EN
//     When defined, a CRC-16-CCITT of the sampled RGB stream is produced
//     per frame on frame_crc, qualified by a one-cycle crc_valid pulse.
//
// Ports
//   CLK100MHZ    in   system clock, all state on the rising edge
//   CPU_RESET    in   synchronous reset, active high
//   enable       in   0 forces IDLE; outputs hold their values
//   clr          in   one-cycle pulse clearing err_status/err_count/frame_count
//   vga_hs       in   horizontal sync under test
//   vga_vs       in   vertical sync under test
//   vga_rgb      in   {R,G,B}, 4 bits each
//   locked       out  1 while locked to the frame structure
//   frame_count  out  frames completed while locked (wraps)
//   err_count    out  error events (saturates)
//   err_status   out  sticky flags: [0]H period [1]HS width [2]V total
//                     [3]VS width [4]timeout
//   err_pulse    out  one-cycle strobe per error event
//   line_period  out  last measured HS-to-HS period in clk cycles
//   frame_crc    out  (VGA_MON_CRC_EN) CRC of the previous frame
//   crc_valid    out  (VGA_MON_CRC_EN) one-cycle strobe with frame_crc
module vga_timing_monitor #(
  parameter int CNT_W           = 16,
  parameter int H_TOTAL_CLKS    = 3200,
  parameter int H_SYNC_CLKS     = 384,
  parameter int V_TOTAL_LINES   = 525,
  parameter int V_SYNC_LINES    = 2,
  parameter int TOL_CLKS        = 2,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int CLK_DIV         = 4
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESET,
  input  logic             enable,
  input  logic             clr,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic [11:0]      vga_rgb,
  output logic             locked,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count,
  output logic [4:0]       err_status,
  output logic             err_pulse,
  output logic [CNT_W-1:0] line_period
`ifdef VGA_MON_CRC_EN
  ,
  output logic [15:0]      frame_crc,
  output logic             crc_valid
`endif
);

  localparam logic ACT_LOW = (SYNC_ACTIVE_LOW != 0);

  localparam logic [CNT_W-1:0] H_MIN =
    CNT_W'((H_TOTAL_CLKS > TOL_CLKS) ? (H_TOTAL_CLKS - TOL_CLKS) : 0);
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL_CLKS + TOL_CLKS);
  localparam logic [CNT_W-1:0] W_MIN =
    CNT_W'((H_SYNC_CLKS > TOL_CLKS) ? (H_SYNC_CLKS - TOL_CLKS) : 0);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(H_SYNC_CLKS + TOL_CLKS);
  localparam logic [CNT_W-1:0] V_TOT = CNT_W'(V_TOTAL_LINES);
  localparam logic [CNT_W-1:0] V_SYN = CNT_W'(V_SYNC_LINES);
  localparam logic [CNT_W-1:0] T_OUT = CNT_W'(2 * H_TOTAL_CLKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_VS = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           state;
  state_t           state_nxt;

  logic             hs_p0;
  logic             hs_p1;
  logic             vs_p0;
  logic             vs_p1;

  logic             hs_rise;
  logic             hs_fall;
  logic             vs_rise;
  logic             vs_fall;

  logic             in_lock;
  logic             lock_evt;
  logic             timeout;
  logic [4:0]       flags;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic             h_seen;
  logic             v_seen;

  // ---- stage p0: sync pins registered, polarity normalised (1 = active)
  // ---- stage p1: previous p0 copy for edge detection
  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      hs_p0 <= 1'b0;
      vs_p0 <= 1'b0;
      hs_p1 <= 1'b0;
      vs_p1 <= 1'b0;
    end else begin
      hs_p0 <= vga_hs ^ ACT_LOW;
      vs_p0 <= vga_vs ^ ACT_LOW;
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
    end
  end

  assign hs_rise = hs_p0 & ~hs_p1;
  assign hs_fall = ~hs_p0 & hs_p1;
  assign vs_rise = vs_p0 & ~vs_p1;
  assign vs_fall = ~vs_p0 & vs_p1;

  // Checks run only while locked and still enabled; the cycle in which
  // enable drops is treated as already idle.
  assign in_lock  = (state == S_LOCKED) && enable;
  assign lock_evt = (state == S_WAIT_VS) && enable && vs_rise;
  assign timeout  = in_lock && !hs_rise && (h_cnt >= T_OUT);
  assign locked   = (state == S_LOCKED);

  // ---- FSM
  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (enable) state_nxt = S_WAIT_VS;
      S_WAIT_VS: begin
        if (!enable)      state_nxt = S_IDLE;
        else if (vs_rise) state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        if (!enable)      state_nxt = S_IDLE;
        else if (timeout) state_nxt = S_WAIT_VS;
      end
      default:            state_nxt = S_IDLE;
    endcase
  end

  // h_seen/v_seen gate the period checks: the first line and first frame
  // after lock are partial and must not be judged.
  always_comb begin
    flags = 5'b0;
    if (in_lock) begin
      if (hs_rise && h_seen && ((h_cnt < H_MIN) || (h_cnt > H_MAX))) flags[0] = 1'b1;
      if (hs_fall && h_seen && ((h_cnt < W_MIN) || (h_cnt > W_MAX))) flags[1] = 1'b1;
      if (vs_rise && v_seen && (line_cnt != V_TOT))                  flags[2] = 1'b1;
      if (vs_fall && (line_cnt != V_SYN))                            flags[3] = 1'b1;
      if (timeout)                                                   flags[4] = 1'b1;
    end
  end

  // ---- measurement counters
  // h_cnt is 1 on the cycle after an HS leading edge, so at the next
  // leading edge it holds the full period and at the trailing edge it holds
  // the active width. A coincident HS edge is folded into a restart so no
  // line is lost.
  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      h_cnt    <= '0;
      line_cnt <= '0;
      h_seen   <= 1'b0;
      v_seen   <= 1'b0;
    end else if (lock_evt) begin
      h_cnt    <= hs_rise ? CNT_W'(1) : '0;
      line_cnt <= hs_rise ? CNT_W'(1) : '0;
      h_seen   <= hs_rise;
      v_seen   <= 1'b0;
    end else if (in_lock) begin
      h_cnt <= hs_rise ? CNT_W'(1) : sat_inc(h_cnt);
      if (hs_rise) h_seen <= 1'b1;
      if (vs_rise) begin
        line_cnt <= hs_rise ? CNT_W'(1) : '0;
        v_seen   <= 1'b1;
      end else if (hs_rise) begin
        line_cnt <= sat_inc(line_cnt);
      end
    end
  end

  // ---- result registers
  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      frame_count <= '0;
      err_count   <= '0;
      err_status  <= 5'b0;
      err_pulse   <= 1'b0;
      line_period <= '0;
    end else begin
      if (in_lock && hs_rise) line_period <= h_cnt;
      if (clr) begin
        // A concurrent error is intentionally dropped.
        frame_count <= '0;
        err_count   <= '0;
        err_status  <= 5'b0;
        err_pulse   <= 1'b0;
      end else begin
        if (in_lock && vs_rise) frame_count <= frame_count + CNT_W'(1);
        err_pulse <= |flags;
        if (|flags) begin
          err_status <= err_status | flags;
          err_count  <= sat_inc(err_count);
        end
      end
    end
  end

`ifdef VGA_MON_CRC_EN
  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [11:0]     rgb_p0;
  logic [PH_W-1:0] ph_cnt;
  logic [PH_W-1:0] ph_base;
  logic [PH_W-1:0] ph_nxt;
  logic            take;
  logic [15:0]     crc;

  // The pixel phase runs in every state so that it is already aligned to
  // the HS edges when lock is acquired; only the sampling is gated.
  assign ph_base = hs_rise ? '0 : ph_cnt;
  assign ph_nxt  = (ph_base == PH_LAST) ? '0 : ph_base + PH_W'(1);
  assign take    = in_lock && (ph_base == '0);

  // ---- stage p0: RGB registered alongside hs_p0/vs_p0
  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      rgb_p0    <= '0;
      ph_cnt    <= '0;
      crc       <= 16'hFFFF;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      rgb_p0    <= vga_rgb;
      ph_cnt    <= ph_nxt;
      crc_valid <= 1'b0;
      if (lock_evt) begin
        crc <= 16'hFFFF;
      end else if (in_lock) begin
        // The VS edge cycle itself is not sampled, so every full frame
        // covers the same number of pixel slots.
        if (vs_rise) begin
          frame_crc <= crc;
          crc_valid <= 1'b1;
          crc       <= 16'hFFFF;
        end else if (take) begin
          crc <= crc12(crc, rgb_p0);
        end
      end
    end
  end
`else
  localparam int CLK_DIV_unused = CLK_DIV;
  logic rgb_unused;
  assign rgb_unused = ^vga_rgb;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
module tb_vga_timing_monitor;

  localparam int CNT_W = 16;
  localparam int HT    = 64;   // clk cycles per line
  localparam int HW    = 8;    // HS active width
  localparam int VT    = 10;   // lines per frame
  localparam int VSL   = 2;    // VS active lines
  localparam int TOL   = 2;
  localparam int CDIV  = 4;
  localparam int HPOS  = 32;   // HS pulse start within a line

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             clr;
  logic             vga_hs;
  logic             vga_vs;
  logic [11:0]      vga_rgb;
  logic             locked;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] err_count;
  logic [4:0]       err_status;
  logic             err_pulse;
  logic [CNT_W-1:0] line_period;
`ifdef VGA_MON_CRC_EN
  logic [15:0]      frame_crc;
  logic             crc_valid;
  logic [15:0]      crc_hist[$];
`endif

  always #5 clk = ~clk;

  vga_timing_monitor #(
    .CNT_W(CNT_W), .H_TOTAL_CLKS(HT), .H_SYNC_CLKS(HW), .V_TOTAL_LINES(VT),
    .V_SYNC_LINES(VSL), .TOL_CLKS(TOL), .SYNC_ACTIVE_LOW(1), .CLK_DIV(CDIV)
  ) dut (
    .CLK100MHZ(clk), .CPU_RESET(rst), .enable(enable), .clr(clr),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
    .locked(locked), .frame_count(frame_count), .err_count(err_count),
    .err_status(err_status), .err_pulse(err_pulse), .line_period(line_period)
`ifdef VGA_MON_CRC_EN
    , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
  );

  int total  = 0;
  int bad    = 0;
  int npulse = 0;

  typedef struct {
    string      tag;
    logic [4:0] status;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every err_pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (err_pulse === 1'b1) begin
      exp_t e;
      npulse++;
      check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.tag, 32'(err_status), 32'(e.status));
      end
    end
  end

`ifdef VGA_MON_CRC_EN
  always @(negedge clk) begin
    if (crc_valid === 1'b1) crc_hist.push_back(frame_crc);
  end
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Active-low pins: active level drives 0.
  task automatic drive(input bit hs_act, input bit vs_act);
    vga_hs = hs_act ? 1'b0 : 1'b1;
    vga_vs = vs_act ? 1'b0 : 1'b1;
    tick();
  endtask

  task automatic send_line(input int len, input int hs_w, input bit vs_act);
    for (int c = 0; c < len; c++) drive((c >= HPOS) && (c < HPOS + hs_w), vs_act);
  endtask

  task automatic send_frame(input int n_lines, input int long_line,
                            input int wide_line, input int wide_w);
    for (int l = 0; l < n_lines; l++)
      send_line((l == long_line) ? HT + 10 : HT,
                (l == wide_line) ? wide_w : HW,
                l < VSL);
  endtask

  task automatic push_exp(input string tag, input logic [4:0] st);
    exp_t e;
    e.tag    = tag;
    e.status = st;
    exp_q.push_back(e);
  endtask

  initial begin
    int p0;
    rst     = 1'b1;
    enable  = 1'b0;
    clr     = 1'b0;
    vga_hs  = 1'b1;
    vga_vs  = 1'b1;
    vga_rgb = 12'h000;
    repeat (3) tick();

    // Reset state
    check("rst_locked",      32'(locked),      32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_err_count",   32'(err_count),   32'd0);
    check("rst_err_status",  32'(err_status),  32'd0);
    check("rst_err_pulse",   32'(err_pulse),   32'd0);
    check("rst_line_period", 32'(line_period), 32'd0);

    rst    = 1'b0;
    enable = 1'b1;
    repeat (5) drive(1'b0, 1'b0);

    // Nominal stream, 3 frames
    for (int f = 0; f < 3; f++) send_frame(VT, -1, -1, 0);
    check("nom_locked",      32'(locked),      32'd1);
    check("nom_frame_count", 32'(frame_count), 32'd2);
    check("nom_err_status",  32'(err_status),  32'd0);
    check("nom_err_count",   32'(err_count),   32'd0);
    check("nom_line_period", 32'(line_period), 32'(HT));
`ifdef VGA_MON_CRC_EN
    check("crc_valid_count", 32'(crc_hist.size()), 32'd2);
    if (crc_hist.size() >= 2) check("crc_equal", 32'(crc_hist[1]), 32'(crc_hist[0]));
`endif

    // One long line
    p0 = npulse;
    push_exp("h_period", 5'b00001);
    send_frame(VT, 4, -1, 0);
    check("hper_status", 32'(err_status), 32'h01);
    check("hper_count",  32'(err_count),  32'd1);
    check("hper_pulses", 32'(npulse - p0), 32'd1);
    check("hper_line_period", 32'(line_period), 32'(HT));

    // HS width out of tolerance, then just inside
    p0 = npulse;
    push_exp("hs_width", 5'b00011);
    send_frame(VT, -1, 3, HW + 6);
    check("hsw_status", 32'(err_status), 32'h03);
    check("hsw_count",  32'(err_count),  32'd2);
    send_frame(VT, -1, 3, HW + 1);
    check("hsw_ok_count",  32'(err_count),   32'd2);
    check("hsw_ok_pulses", 32'(npulse - p0), 32'd1);

    // Short frame, flagged at the following VS leading edge
    push_exp("v_total", 5'b00111);
    send_frame(VT - 1, -1, -1, 0);
    send_frame(VT, -1, -1, 0);
    check("vtot_status", 32'(err_status), 32'h07);
    check("vtot_count",  32'(err_count),  32'd3);
    check("vtot_queue",  32'(exp_q.size()), 32'd0);

    // clr, then HS stuck until timeout
    clr = 1'b1;
    drive(1'b0, 1'b0);
    clr = 1'b0;
    check("clr_status", 32'(err_status),  32'd0);
    check("clr_count",  32'(err_count),   32'd0);
    check("clr_frames", 32'(frame_count), 32'd0);
    push_exp("timeout", 5'b10000);
    repeat (2 * HT + 10) drive(1'b0, 1'b0);
    check("tmo_status", 32'(err_status), 32'h10);
    check("tmo_locked", 32'(locked),     32'd0);
    check("tmo_count",  32'(err_count),  32'd1);

    // Relock on the next VS edge
    send_frame(VT, -1, -1, 0);
    check("relock_locked", 32'(locked),        32'd1);
    check("relock_count",  32'(err_count),     32'd1);
    check("relock_queue",  32'(exp_q.size()),  32'd0);
    for (int l = 0; l < 4; l++) send_line(HT, HW, l < VSL);
    check("relock_frames", 32'(frame_count), 32'd1);

    // Reset mid-frame
    rst = 1'b1;
    drive(1'b0, 1'b0);
    rst = 1'b0;
    check("mid_rst_locked",      32'(locked),      32'd0);
    check("mid_rst_frame_count", 32'(frame_count), 32'd0);
    check("mid_rst_err_count",   32'(err_count),   32'd0);
    check("mid_rst_err_status",  32'(err_status),  32'd0);
    check("mid_rst_err_pulse",   32'(err_pulse),   32'd0);
    check("mid_rst_line_period", 32'(line_period), 32'd0);
`ifdef VGA_MON_CRC_EN
    check("mid_rst_frame_crc", 32'(frame_crc), 32'd0);
    check("mid_rst_crc_valid", 32'(crc_valid), 32'd0);
`endif
    repeat (4) drive(1'b0, 1'b0);
    check("end_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
